// File: rtl/aes_mcol_iter.sv
// Iterative MixColumns / InvMixColumns stage.
// A full State is captured on the input handshake. COLS_PER_CYC columns are
// then transformed in place per clock by shared GF(2^8) column logic. The
// finished State is held on the output port until downstream accepts it.
// Byte 4*j+i of the State is row i, column j.
module aes_mcol_iter #(
  parameter  int COLS_PER_CYC = 1,
  localparam int NB           = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_inv,
  input  logic [7:0] State_in  [0:4*NB-1],
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] State_out [0:4*NB-1],
  output logic       busy
);

  localparam int PW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [PW-1:0] LAST_COL = PW'(NB - COLS_PER_CYC);
  localparam logic [PW-1:0] STEP     = PW'(COLS_PER_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_reg;
  state_e          state_next;
  logic [PW-1:0]   cnt_reg;
  logic            inv_reg;
  logic            load;
  logic [7:0]      work_reg  [0:4*NB-1];
  logic [7:0]      work_next [0:4*NB-1];
  logic [PW-1:0]   mix_col   [COLS_PER_CYC];
  logic [3:0][7:0] mix_res   [COLS_PER_CYC];

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k, built from a chain of xt steps.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  // One column through either the forward or the inverse matrix.
  function automatic logic [3:0][7:0] mix_column(input logic [3:0][7:0] a, input logic inv);
    logic [3:0][7:0] r;
    logic [7:0]      a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) begin
      a0 = a[2'(i)];
      a1 = a[2'(i + 1)];
      a2 = a[2'(i + 2)];
      a3 = a[2'(i + 3)];
      if (inv)
        r[2'(i)] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      else
        r[2'(i)] = gf_mul(a0, 4'h2) ^ gf_mul(a1, 4'h3) ^ a2 ^ a3;
    end
    return r;
  endfunction

  assign load = in_valid & in_ready;

  // Column lanes: lane gi works on column cnt_reg+gi of the work register.
  for (genvar gi = 0; gi < COLS_PER_CYC; gi++) begin : g_lane
    logic [3:0][7:0] col_in;
    assign mix_col[gi] = cnt_reg + PW'(gi);
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      assign col_in[gj] = work_reg[{mix_col[gi], 2'(gj)}];
    end
    assign mix_res[gi] = mix_column(col_in, inv_reg);
  end

  // Per-byte next value. Groups are aligned to multiples of COLS_PER_CYC,
  // so each byte has a fixed lane and a fixed counter value at which it updates.
  for (genvar bi = 0; bi < 4 * NB; bi++) begin : g_byte
    localparam int CB   = bi / 4;
    localparam int RB   = bi % 4;
    localparam int GB   = CB % COLS_PER_CYC;
    localparam int BASE = CB - GB;
    assign work_next[bi] = load ? State_in[bi] :
                           ((state_reg == CALC) && (cnt_reg == PW'(BASE))) ? mix_res[GB][RB] :
                           work_reg[bi];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = CALC;
      CALC:    if (cnt_reg == LAST_COL) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = reset;
      CALC:    busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: work register, column counter and direction flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      work_reg <= '{default: 8'h00};
      cnt_reg  <= '0;
      inv_reg  <= 1'b0;
    end else begin
      work_reg <= work_next;
      if (load) begin
        inv_reg <= in_inv;
        cnt_reg <= '0;
      end else if (state_reg == CALC) begin
        cnt_reg <= cnt_reg + STEP;
      end
    end
  end

  assign State_out = work_reg;

endmodule

// File: tb/tb_aes_mcol_iter.sv
// Directed bench for aes_mcol_iter: one DUT with one column per clock and
// one with two columns per clock, sharing clock and reset.
module tb_aes_mcol_iter;

  typedef logic [7:0] state_t [0:15];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n;
  logic   in_valid, in_inv, out_ready, in_ready, out_valid, busy;
  logic   in_valid2, in_inv2, out_ready2, in_ready2, out_valid2, busy2;
  state_t st_in, st_out, st_in2, st_out2;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] BLK_A     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] BLK_A_MIX = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BLK_B     = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] BLK_B_MIX = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

  aes_mcol_iter #(.COLS_PER_CYC(1)) dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .State_in(st_in), .out_valid(out_valid),
    .out_ready(out_ready), .State_out(st_out), .busy(busy)
  );

  aes_mcol_iter #(.COLS_PER_CYC(2)) dut2 (
    .clock(clk), .reset(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_inv(in_inv2), .State_in(st_in2), .out_valid(out_valid2),
    .out_ready(out_ready2), .State_out(st_out2), .busy(busy2)
  );

  function automatic state_t unpack16(input logic [127:0] v);
    state_t s;
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    return s;
  endfunction

  function automatic logic [127:0] pack16(input state_t s);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  // Present one block to dut for exactly one clock edge.
  task automatic send(input logic [127:0] v, input logic inv);
    @(negedge clk);
    st_in    = unpack16(v);
    in_inv   = inv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count clocks until dut raises out_valid (bounded at 20).
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if ({in_ready, busy} !== 2'b00) $display("FAIL reset_ready_busy: got %b expected 00", {in_ready, busy});
    else n_pass++;
    n_checks++;
    if (pack16(st_out) !== 128'h0) $display("FAIL reset_state_out: got %h expected 0", pack16(st_out));
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_forward();
    int cyc;
    send(BLK_A, 1'b0);
    wait_out(cyc);
    n_checks++;
    if (cyc !== 4) $display("FAIL fwd_latency: got %0d expected 4", cyc);
    else n_pass++;
    n_checks++;
    if (pack16(st_out) !== BLK_A_MIX) $display("FAIL fwd_data: got %h expected %h", pack16(st_out), BLK_A_MIX);
    else n_pass++;
    n_checks++;
    if ({busy, in_ready} !== 2'b10) $display("FAIL fwd_done_status: got %b expected 10", {busy, in_ready});
    else n_pass++;
    release_out();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL fwd_back_idle: got %b expected 100", {in_ready, out_valid, busy});
    else n_pass++;
  endtask

  task automatic test_inverse();
    int cyc;
    send(BLK_A_MIX, 1'b1);
    wait_out(cyc);
    n_checks++;
    if (pack16(st_out) !== BLK_A || cyc !== 4) $display("FAIL inv_data: got %h after %0d expected %h after 4", pack16(st_out), cyc, BLK_A);
    else n_pass++;
    release_out();
  endtask

  task automatic test_vectors2();
    int cyc;
    send(BLK_B, 1'b0);
    wait_out(cyc);
    n_checks++;
    if (pack16(st_out) !== BLK_B_MIX) $display("FAIL fwd2_data: got %h expected %h", pack16(st_out), BLK_B_MIX);
    else n_pass++;
    release_out();
    send(BLK_B_MIX, 1'b1);
    wait_out(cyc);
    n_checks++;
    if (pack16(st_out) !== BLK_B) $display("FAIL inv2_data: got %h expected %h", pack16(st_out), BLK_B);
    else n_pass++;
    release_out();
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic stable;
    send(BLK_A, 1'b0);
    wait_out(cyc);
    stable   = (cyc == 4);
    st_in    = unpack16(BLK_B);
    in_inv   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || pack16(st_out) !== BLK_A_MIX)
        stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) $display("FAIL bp_hold: got out %h valid %b ready %b expected %h 1 0", pack16(st_out), out_valid, in_ready, BLK_A_MIX);
    else n_pass++;
    in_valid = 1'b0;
    release_out();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL bp_release_idle: got %b expected 100", {in_ready, out_valid, busy});
    else n_pass++;
    n_checks++;
    if (pack16(st_out) !== BLK_A_MIX) $display("FAIL bp_ignored_input: got %h expected %h", pack16(st_out), BLK_A_MIX);
    else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    int   cyc;
    logic quiet;
    send(BLK_A, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) $display("FAIL abort_status: got %b expected 000", {out_valid, busy, in_ready});
    else n_pass++;
    n_checks++;
    if (pack16(st_out) !== 128'h0) $display("FAIL abort_state_out: got %h expected 0", pack16(st_out));
    else n_pass++;
    rst_n = 1'b1;
    #1;
    quiet = in_ready;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) $display("FAIL abort_no_output: got valid %b ready %b expected 0 1", out_valid, in_ready);
    else n_pass++;
    send(BLK_B, 1'b0);
    wait_out(cyc);
    n_checks++;
    if (pack16(st_out) !== BLK_B_MIX || cyc !== 4) $display("FAIL abort_next_block: got %h after %0d expected %h after 4", pack16(st_out), cyc, BLK_B_MIX);
    else n_pass++;
    release_out();
  endtask

  // Blocks streamed with in_valid held high and out_ready tied high.
  // which selects the DUT: 1 = one column per clock, 2 = two columns per clock.
  task automatic test_back_to_back(input int which);
    logic [127:0] ins  [3];
    logic [127:0] exps [3];
    logic         invs [3];
    logic [127:0] got;
    int           lat, gap, k, r, last;
    logic         rdy, vld;
    ins  = '{BLK_A, BLK_B, BLK_A_MIX};
    exps = '{BLK_A_MIX, BLK_B_MIX, BLK_A};
    invs = '{1'b0, 1'b0, 1'b1};
    lat  = (which == 2) ? 2 : 4;
    gap  = lat + 2;
    k    = 0;
    r    = 0;
    last = 0;
    @(negedge clk);
    if (which == 2) out_ready2 = 1'b1;
    else            out_ready  = 1'b1;
    for (int c = 0; c < 60 && r < 3; c++) begin
      rdy = (which == 2) ? in_ready2 : in_ready;
      if (rdy) begin
        if (which == 2) begin
          in_valid2 = (k < 3);
          if (k < 3) begin st_in2 = unpack16(ins[k]); in_inv2 = invs[k]; end
        end else begin
          in_valid = (k < 3);
          if (k < 3) begin st_in = unpack16(ins[k]); in_inv = invs[k]; end
        end
        if (k < 3) k++;
      end
      @(negedge clk);
      vld = (which == 2) ? out_valid2 : out_valid;
      got = (which == 2) ? pack16(st_out2) : pack16(st_out);
      if (vld) begin
        n_checks++;
        if (got !== exps[r]) $display("FAIL b2b%0d_data%0d: got %h expected %h", which, r, got, exps[r]);
        else n_pass++;
        n_checks++;
        if (r == 0 && c !== lat) $display("FAIL b2b%0d_latency: got %0d expected %0d", which, c, lat);
        else if (r > 0 && c - last !== gap) $display("FAIL b2b%0d_period%0d: got %0d expected %0d", which, r, c - last, gap);
        else n_pass++;
        last = c;
        r++;
      end
    end
    n_checks++;
    if (r !== 3) $display("FAIL b2b%0d_count: got %0d expected 3", which, r);
    else n_pass++;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_inv     = 1'b0;
    out_ready  = 1'b0;
    st_in      = unpack16(128'h0);
    in_valid2  = 1'b0;
    in_inv2    = 1'b0;
    out_ready2 = 1'b0;
    st_in2     = unpack16(128'h0);
    test_reset();
    test_forward();
    test_inverse();
    test_vectors2();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back(1);
    test_back_to_back(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
